// File: rtl/featuremap_stream_packer.sv
// Packs serial channel words into NUM_CH-wide pixel vectors and streams a
// zero-bordered (IMG_SIZE+2*PAD)^2 frame in raster order.

// One channel slot of the assembly register.
module featuremap_stream_packer_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);
  logic [DATA_WIDTH-1:0] q_q;

  // Capture the channel word addressed to this slot.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)         q_q <= '0;
    else if (wr_en_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module featuremap_stream_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 32,
  parameter int IMG_SIZE   = 104,
  parameter int PAD        = 1
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         start_in,
  input  logic [DATA_WIDTH-1:0]        ch_data_in,
  input  logic                         ch_valid_in,
  output logic                         ch_ready_out,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic                         valid_out,
  output logic                         frame_done,
  output logic                         busy
);
  localparam int DIM = IMG_SIZE + 2*PAD;
  localparam int PW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PW-1:0] POS_MAX = PW'(DIM - 1);
  localparam logic [CW-1:0] CH_MAX  = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_PAD, S_FILL} state_t;

  state_t state_q, state_d;
  logic [PW-1:0] row_q, row_d, col_q, col_d;
  logic [CW-1:0] ch_cnt_q, ch_cnt_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] asm_q, full, data_q, data_d;
  logic [NUM_CH-1:0] wr_en;
  logic valid_q, valid_d, done_q, done_d, busy_q, busy_d;
  logic adv;
  logic [PW-1:0] nrow, ncol;

  // Signed compare keeps the PAD=0 case free of constant unsigned tests.
  function automatic logic is_border(input logic [PW-1:0] r, input logic [PW-1:0] c);
    int ri;
    int ci;
    ri = int'(r);
    ci = int'(c);
    return (ri < PAD) || (ri >= IMG_SIZE + PAD) || (ci < PAD) || (ci >= IMG_SIZE + PAD);
  endfunction

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_slot
      featuremap_stream_packer_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
        .Clk     (Clk),
        .Rst     (Rst),
        .wr_en_i (wr_en[k]),
        .d_i     (ch_data_in),
        .q_o     (asm_q[k])
      );
    end
  endgenerate

  // Slot write strobes and the completed vector with the incoming word merged in.
  always_comb begin
    wr_en = '0;
    full  = asm_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_cnt_q == CW'(i)) begin
        wr_en[i] = ch_valid_in && (state_q == S_FILL);
        full[i]  = ch_data_in;
      end
    end
  end

  // Next-state, position walk and output-register update.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    ch_cnt_d = ch_cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    busy_d   = done_q ? 1'b0 : busy_q;
    adv      = 1'b0;
    nrow     = row_q;
    ncol     = col_q;
    case (state_q)
      S_IDLE: begin
        if (start_in && !busy_q) begin
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b1;
          state_d = is_border('0, '0) ? S_PAD : S_FILL;
        end
      end
      S_PAD: begin
        data_d  = '0;
        valid_d = 1'b1;
        adv     = 1'b1;
      end
      S_FILL: begin
        if (ch_valid_in) begin
          if (ch_cnt_q == CH_MAX) begin
            data_d   = full;
            valid_d  = 1'b1;
            ch_cnt_d = '0;
            adv      = 1'b1;
          end else begin
            ch_cnt_d = ch_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      if (row_q == POS_MAX && col_q == POS_MAX) begin
        row_d   = '0;
        col_d   = '0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        if (col_q == POS_MAX) begin
          ncol = '0;
          nrow = row_q + PW'(1);
        end else begin
          ncol = col_q + PW'(1);
        end
        row_d   = nrow;
        col_d   = ncol;
        state_d = is_border(nrow, ncol) ? S_PAD : S_FILL;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      ch_cnt_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      ch_cnt_q <= ch_cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign ch_ready_out = (state_q == S_FILL);
  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign frame_done   = done_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_featuremap_stream_packer.sv
// Directed bench: a padded 2x2 frame (4 ch x 8 bit) and an unpadded 3x3 frame (2 ch x 8 bit).
module tb_featuremap_stream_packer;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        start0 = 1'b0, valid0 = 1'b0;
  logic [7:0]  data0 = '0;
  logic        ready0, vout0, done0, busy0;
  logic [31:0] dout0;
  logic        start1 = 1'b0, valid1 = 1'b0;
  logic [7:0]  data1 = '0;
  logic        ready1, vout1, done1, busy1;
  logic [15:0] dout1;

  int checks = 0;
  int errors = 0;

  featuremap_stream_packer #(.DATA_WIDTH(8), .NUM_CH(4), .IMG_SIZE(2), .PAD(1)) u0 (
    .Clk(Clk), .Rst(Rst), .start_in(start0), .ch_data_in(data0), .ch_valid_in(valid0),
    .ch_ready_out(ready0), .data_out(dout0), .valid_out(vout0), .frame_done(done0), .busy(busy0));

  featuremap_stream_packer #(.DATA_WIDTH(8), .NUM_CH(2), .IMG_SIZE(3), .PAD(0)) u1 (
    .Clk(Clk), .Rst(Rst), .start_in(start1), .ch_data_in(data1), .ch_valid_in(valid1),
    .ch_ready_out(ready1), .data_out(dout1), .valid_out(vout1), .frame_done(done1), .busy(busy1));

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Output capture for u0.
  logic [31:0] oq[$];
  bit          fq[$];
  int          ocyc[$];
  int          acc_cyc[$];
  int          done_cnt0 = 0, ready_rise = -1, busy_fall = -1;
  bit          ready_prev = 0, busy_prev = 0;
  always @(negedge Clk) begin
    if (vout0) begin
      oq.push_back(dout0);
      fq.push_back(done0);
      ocyc.push_back(cyc);
    end
    if (done0) done_cnt0++;
    if (ready0 && !ready_prev && ready_rise < 0) ready_rise = cyc;
    if (!busy0 && busy_prev && busy_fall < 0) busy_fall = cyc;
    ready_prev = ready0;
    busy_prev  = busy0;
  end

  // Output capture for u1.
  int          o1cnt = 0, o1zero = 0, done1cnt = 0, done1_pulse = -1, rlow1 = 0;
  logic [15:0] o1last = '0;
  always @(negedge Clk) begin
    if (vout1) begin
      o1cnt++;
      if (dout1 == 16'h0) o1zero++;
      o1last = dout1;
    end
    if (done1) begin
      done1cnt++;
      done1_pulse = o1cnt;
    end
    if (busy1 && !done1 && !ready1) rlow1++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge Clk);
    #1;
    oq.delete(); fq.delete(); ocyc.delete(); acc_cyc.delete();
    done_cnt0 = 0; ready_rise = -1; busy_fall = -1;
  endtask

  // Reference frame for the 4x4 padded raster: border zeros, interior packs 4 words.
  logic [31:0] expv[16];
  task automatic make_exp(input logic [7:0] base);
    logic [7:0] w;
    w = base;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (r < 1 || r > 2 || c < 1 || c > 2) expv[r*4+c] = 32'h0;
        else begin
          expv[r*4+c] = {w + 8'd3, w + 8'd2, w + 8'd1, w};
          w = w + 8'd4;
        end
      end
  endtask

  // Drive one u0 frame; optional extra start pulse and early abort by accepted-word count.
  task automatic run0(input logic [7:0] base, input bit gaps, input int start_at,
                      input int abort_at, output int nwords);
    bit pend, pulsed, stop;
    int to;
    logic [7:0] w;
    pend = 0; pulsed = 0; stop = 0; to = 0; w = base; nwords = 0;
    @(negedge Clk); start0 = 1'b1; valid0 = 1'b0;
    @(negedge Clk); start0 = 1'b0;
    while (done_cnt0 == 0 && to < 600 && !stop) begin
      if (pend) begin
        nwords++;
        w = w + 8'd1;
        acc_cyc.push_back(cyc);
      end
      if (abort_at >= 0 && nwords == abort_at) stop = 1;
      else begin
        start0 = (start_at >= 0 && nwords == start_at && !pulsed);
        if (start0) pulsed = 1;
        valid0 = (nwords < 16) && (gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
        data0  = w;
        pend   = valid0 && ready0;
        to++;
        @(negedge Clk);
      end
    end
    start0 = 1'b0;
    if (!stop) begin
      valid0 = 1'b0;
      chk("frame0_timeout", 64'(to >= 600), 64'd0);
    end
  endtask

  task automatic chk_frame(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_vec%0d", tag, i), (i < oq.size()) ? 64'(oq[i]) : 64'hx, 64'(expv[i]));
    chk({tag, "_count"}, 64'(oq.size()), 64'd16);
    chk({tag, "_done_cnt"}, 64'(done_cnt0), 64'd1);
    chk({tag, "_done_last"}, (fq.size() == 16) ? 64'(fq[15]) : 64'hx, 64'd1);
    chk({tag, "_first_lat"}, (ocyc.size() > 5 && acc_cyc.size() > 3) ? 64'(ocyc[5] - acc_cyc[3]) : 64'hx, 64'd0);
  endtask

  int n;
  int to1;
  bit pend1;
  logic [7:0] w1;

  initial begin
    // 1: asynchronous reset mid-cycle with random inputs
    #3;
    valid0 = 1'b1; data0 = 8'($urandom); valid1 = 1'b1; data1 = 8'($urandom);
    Rst = 1'b0;
    #1;
    chk("rst_async_valid", 64'(vout0), 64'd0);
    chk("rst_async_data",  64'(dout0), 64'd0);
    chk("rst_async_ready", 64'(ready0), 64'd0);
    chk("rst_async_busy",  64'({busy0, done0}), 64'd0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    repeat (4) @(negedge Clk);
    chk("idle_ready", 64'(ready0), 64'd0);
    chk("idle_outs",  64'({vout0, done0, busy0, dout0}), 64'd0);
    valid0 = 1'b0; valid1 = 1'b0;

    // 2: continuous stream
    make_exp(8'h01);
    clear_mon();
    run0(8'h01, 1'b0, -1, -1, n);
    repeat (3) @(negedge Clk);
    chk("s2_words", 64'(n), 64'd16);
    chk_frame("s2");
    chk("s2_first_interior", (oq.size() > 5) ? 64'(oq[5]) : 64'hx, 64'h04030201);
    chk("s2_pad_run", (ocyc.size() > 4) ? 64'(ocyc[4] - ocyc[0]) : 64'hx, 64'd4);
    chk("s2_ready_rise", (ocyc.size() > 4) ? 64'(ready_rise - ocyc[4]) : 64'hx, 64'd0);
    chk("s2_busy_fall", (ocyc.size() == 16) ? 64'(busy_fall - ocyc[15]) : 64'hx, 64'd1);

    // 3: gapped input
    clear_mon();
    run0(8'h01, 1'b1, -1, -1, n);
    repeat (3) @(negedge Clk);
    chk("s3_words", 64'(n), 64'd16);
    chk_frame("s3");

    // 4: start while busy
    clear_mon();
    run0(8'h01, 1'b0, 2, -1, n);
    repeat (10) @(negedge Clk);
    chk("s4_words", 64'(n), 64'd16);
    chk_frame("s4");
    chk("s4_no_restart", 64'({busy0, ready0}), 64'd0);

    // 5: reset two words into the second interior pixel, then restart
    clear_mon();
    run0(8'h01, 1'b0, -1, 6, n);
    chk("s5_pre_data", 64'(dout0), 64'h04030201);
    chk("s5_pre_busy", 64'(busy0), 64'd1);
    #2;
    Rst = 1'b0;
    #1;
    chk("s5_rst_data",  64'(dout0), 64'd0);
    chk("s5_rst_ctrl",  64'({busy0, ready0, vout0, done0}), 64'd0);
    valid0 = 1'b1; data0 = 8'h55;
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    valid0 = 1'b0;
    make_exp(8'hA1);
    clear_mon();
    run0(8'hA1, 1'b0, -1, -1, n);
    repeat (3) @(negedge Clk);
    chk("s5_words", 64'(n), 64'd16);
    chk("s5_first_interior", (oq.size() > 5) ? 64'(oq[5]) : 64'hx, 64'hA4A3A2A1);
    chk_frame("s5");

    // 6: PAD=0 frame on u1
    o1cnt = 0; o1zero = 0; done1cnt = 0; done1_pulse = -1; rlow1 = 0;
    @(negedge Clk); start1 = 1'b1;
    @(negedge Clk); start1 = 1'b0;
    n = 0; w1 = 8'h01; pend1 = 0; to1 = 0;
    while (done1cnt == 0 && to1 < 200) begin
      if (pend1) begin
        n++;
        w1 = w1 + 8'd1;
      end
      valid1 = (n < 18);
      data1  = w1;
      pend1  = valid1 && ready1;
      to1++;
      @(negedge Clk);
    end
    valid1 = 1'b0;
    repeat (3) @(negedge Clk);
    chk("s6_timeout", 64'(to1 >= 200), 64'd0);
    chk("s6_words", 64'(n), 64'd18);
    chk("s6_pulses", 64'(o1cnt), 64'd9);
    chk("s6_zero_vecs", 64'(o1zero), 64'd0);
    chk("s6_ready_low", 64'(rlow1), 64'd0);
    chk("s6_done_pulse", 64'(done1_pulse), 64'd9);
    chk("s6_done_cnt", 64'(done1cnt), 64'd1);
    chk("s6_last_vec", 64'(o1last), 64'h1211);
    chk("s6_idle", 64'({busy1, ready1}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
